// File: rtl/amci_arbiter_if.sv
// Signal bundle between two AMCI requesters, the arbiter and one axi4_lite_master AMCI port.
// The arbiter binds the slave modport; the requester FSMs and master binding use the master modport.
interface amci_arbiter_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   // Requester side: per-requester slices packed as [i*W +: W]
   logic [2*AXI_ADDR_WIDTH-1:0] REQ_WADDR;
   logic [2*AXI_DATA_WIDTH-1:0] REQ_WDATA;
   logic [1:0]                  REQ_WRITE;
   logic [3:0]                  REQ_WRESP;
   logic [1:0]                  REQ_WIDLE;
   logic [2*AXI_ADDR_WIDTH-1:0] REQ_RADDR;
   logic [1:0]                  REQ_READ;
   logic [2*AXI_DATA_WIDTH-1:0] REQ_RDATA;
   logic [3:0]                  REQ_RRESP;
   logic [1:0]                  REQ_RIDLE;

   // Master side: the shared AMCI port of the axi4_lite_master
   logic [AXI_ADDR_WIDTH-1:0]   AMCI_WADDR;
   logic [AXI_DATA_WIDTH-1:0]   AMCI_WDATA;
   logic                        AMCI_WRITE;
   logic [1:0]                  AMCI_WRESP;
   logic                        AMCI_WIDLE;
   logic [AXI_ADDR_WIDTH-1:0]   AMCI_RADDR;
   logic                        AMCI_READ;
   logic [AXI_DATA_WIDTH-1:0]   AMCI_RDATA;
   logic [1:0]                  AMCI_RRESP;
   logic                        AMCI_RIDLE;

   modport slave (
      input  REQ_WADDR, REQ_WDATA, REQ_WRITE, REQ_RADDR, REQ_READ,
      input  AMCI_WRESP, AMCI_WIDLE, AMCI_RDATA, AMCI_RRESP, AMCI_RIDLE,
      output REQ_WRESP, REQ_WIDLE, REQ_RDATA, REQ_RRESP, REQ_RIDLE,
      output AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ
   );

   modport master (
      output REQ_WADDR, REQ_WDATA, REQ_WRITE, REQ_RADDR, REQ_READ,
      output AMCI_WRESP, AMCI_WIDLE, AMCI_RDATA, AMCI_RRESP, AMCI_RIDLE,
      input  REQ_WRESP, REQ_WIDLE, REQ_RDATA, REQ_RRESP, REQ_RIDLE,
      input  AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ
   );
endinterface

// File: rtl/amci_arbiter.sv
// Two-requester round-robin arbiter in front of one axi4_lite_master AMCI port.
// Write and read channels run independent IDLE -> SETTLE -> WAIT FSMs and pointers.
module amci_arbiter #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          resetn,
   amci_arbiter_if.slave bus,
   output logic [1:0]    dbg_wstate,
   output logic [1:0]    dbg_rstate
);
   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;

   // Handshake: a requester may pulse REQ_WRITE/READ[i] for one cycle only while
   // REQ_WIDLE/RIDLE[i]=1; the idle bit stays low until that request's response
   // is latched. Toward the master, AMCI_WRITE/READ is a one-cycle start pulse
   // issued only while AMCI_WIDLE/RIDLE=1, and completion is the idle bit rising.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2
   } chan_state_t;

   chan_state_t   w_state, r_state;
   logic [1:0]    pending_w, pending_r;
   logic          w_ptr, r_ptr;
   logic          w_grant, r_grant;
   logic          w_pick, r_pick;
   logic [AW-1:0] w_addr_slot [2];
   logic [DW-1:0] w_data_slot [2];
   logic [AW-1:0] r_addr_slot [2];

   // Single pending requester wins outright; the pointer only breaks ties.
   function automatic logic pick(input logic [1:0] pend, input logic ptr);
      return (pend == 2'b11) ? ptr : pend[1];
   endfunction

   assign w_pick = pick(pending_w, w_ptr);
   assign r_pick = pick(pending_r, r_ptr);

   assign bus.REQ_WIDLE = ~pending_w;
   assign bus.REQ_RIDLE = ~pending_r;

   assign dbg_wstate = w_state;
   assign dbg_rstate = r_state;

   // ---------------------------------------------------------------- write
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_state        <= ST_IDLE;
         w_ptr          <= 1'b0;
         w_grant        <= 1'b0;
         pending_w      <= 2'b00;
         w_addr_slot[0] <= '0;
         w_addr_slot[1] <= '0;
         w_data_slot[0] <= '0;
         w_data_slot[1] <= '0;
         bus.AMCI_WADDR <= '0;
         bus.AMCI_WDATA <= '0;
         bus.AMCI_WRITE <= 1'b0;
         bus.REQ_WRESP  <= '0;
      end else begin
         // Capture is gated by the pre-update idle bit, so a pulse landing on
         // the completion cycle is dropped rather than queued.
         for (int i = 0; i < 2; i++) begin
            if (bus.REQ_WRITE[i] && !pending_w[i]) begin
               pending_w[i]   <= 1'b1;
               w_addr_slot[i] <= bus.REQ_WADDR[i*AW +: AW];
               w_data_slot[i] <= bus.REQ_WDATA[i*DW +: DW];
            end
         end

         case (w_state)
            ST_IDLE: begin
               if ((pending_w != 2'b00) && bus.AMCI_WIDLE) begin
                  w_grant        <= w_pick;
                  bus.AMCI_WADDR <= w_addr_slot[w_pick];
                  bus.AMCI_WDATA <= w_data_slot[w_pick];
                  bus.AMCI_WRITE <= 1'b1;
                  w_state        <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Master is still raising its busy flag; WIDLE is stale here.
               bus.AMCI_WRITE <= 1'b0;
               w_state        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.AMCI_WIDLE) begin
                  if (w_grant) bus.REQ_WRESP[3:2] <= bus.AMCI_WRESP;
                  else         bus.REQ_WRESP[1:0] <= bus.AMCI_WRESP;
                  pending_w[w_grant] <= 1'b0;
                  w_ptr              <= ~w_grant;
                  w_state            <= ST_IDLE;
               end
            end
            default: begin
               bus.AMCI_WRITE <= 1'b0;
               w_state        <= ST_IDLE;
            end
         endcase
      end
   end

   // ----------------------------------------------------------------- read
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= ST_IDLE;
         r_ptr          <= 1'b0;
         r_grant        <= 1'b0;
         pending_r      <= 2'b00;
         r_addr_slot[0] <= '0;
         r_addr_slot[1] <= '0;
         bus.AMCI_RADDR <= '0;
         bus.AMCI_READ  <= 1'b0;
         bus.REQ_RRESP  <= '0;
         bus.REQ_RDATA  <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (bus.REQ_READ[i] && !pending_r[i]) begin
               pending_r[i]   <= 1'b1;
               r_addr_slot[i] <= bus.REQ_RADDR[i*AW +: AW];
            end
         end

         case (r_state)
            ST_IDLE: begin
               if ((pending_r != 2'b00) && bus.AMCI_RIDLE) begin
                  r_grant        <= r_pick;
                  bus.AMCI_RADDR <= r_addr_slot[r_pick];
                  bus.AMCI_READ  <= 1'b1;
                  r_state        <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               bus.AMCI_READ <= 1'b0;
               r_state       <= ST_WAIT;
            end
            ST_WAIT: begin
               // Only the granted requester's data/resp slice moves; the other holds.
               if (bus.AMCI_RIDLE) begin
                  if (r_grant) begin
                     bus.REQ_RRESP[3:2]         <= bus.AMCI_RRESP;
                     bus.REQ_RDATA[2*DW-1:DW]   <= bus.AMCI_RDATA;
                  end else begin
                     bus.REQ_RRESP[1:0]         <= bus.AMCI_RRESP;
                     bus.REQ_RDATA[DW-1:0]      <= bus.AMCI_RDATA;
                  end
                  pending_r[r_grant] <= 1'b0;
                  r_ptr              <= ~r_grant;
                  r_state            <= ST_IDLE;
               end
            end
            default: begin
               bus.AMCI_READ <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
